// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default
// geometry, the hard-wired zero register and the grant encoding.
package regfile_wb_arbiter_pkg;

  localparam int ADDR_SIZE_DEF = 5;
  localparam int WORD_SIZE_DEF = 32;
  localparam int ZERO_REG      = 0;

  // Which requester owns the write port; also the round-robin history.
  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage : regfile_wb_arbiter_pkg

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin selector. A lone requester always wins; on
// contention the requester that did not win last time is granted.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic   a_valid_i,
  input  logic   b_valid_i,
  input  grant_e last_grant_i,
  output logic   a_gnt_o,
  output logic   b_gnt_o
);

  // Pick at most one requester from the valids and the grant history.
  always_comb begin
    a_gnt_o = 1'b0;
    b_gnt_o = 1'b0;
    if (a_valid_i && b_valid_i) begin
      if (last_grant_i == GRANT_B) begin
        a_gnt_o = 1'b1;
      end else begin
        b_gnt_o = 1'b1;
      end
    end else if (a_valid_i) begin
      a_gnt_o = 1'b1;
    end else if (b_valid_i) begin
      b_gnt_o = 1'b1;
    end else begin
      a_gnt_o = 1'b0;
      b_gnt_o = 1'b0;
    end
  end

endmodule : rr_arbiter2

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of a single register-file write port.
// Requester A (ALU) and requester B (multi-cycle units) share the port
// round-robin; the winning write is registered and appears one cycle later.
// Optional pending-write scoreboard (busy_o) is built only when the macro
// REGFILE_WB_SCOREBOARD_EN is defined; otherwise busy_o is constant zero.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    a_valid_i,
  input  logic [ADDR_SIZE-1:0]    a_rd_i,
  input  logic [WORD_SIZE-1:0]    a_data_i,
  output logic                    a_ready_o,
  input  logic                    b_valid_i,
  input  logic [ADDR_SIZE-1:0]    b_rd_i,
  input  logic [WORD_SIZE-1:0]    b_data_i,
  output logic                    b_ready_o,
  output logic                    rd_en_o,
  output logic [ADDR_SIZE-1:0]    rd_o,
  output logic [WORD_SIZE-1:0]    rd_data_o,
  input  logic                    issue_en_i,
  input  logic [ADDR_SIZE-1:0]    issue_rd_i,
  output logic [2**ADDR_SIZE-1:0] busy_o
);

  localparam logic [ADDR_SIZE-1:0] ZERO_RD = ADDR_SIZE'(ZERO_REG);

  grant_e                 last_grant_q, last_grant_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_SIZE-1:0]   rd_q, rd_d;
  logic [WORD_SIZE-1:0]   rd_data_q, rd_data_d;
  logic                   a_gnt, b_gnt;
  logic                   a_hs, b_hs;

  rr_arbiter2 u_rr (
    .a_valid_i    (a_valid_i),
    .b_valid_i    (b_valid_i),
    .last_grant_i (last_grant_q),
    .a_gnt_o      (a_gnt),
    .b_gnt_o      (b_gnt)
  );

  // Readies are suppressed during reset so no handshake can complete.
  assign a_ready_o = a_gnt & rst_ni;
  assign b_ready_o = b_gnt & rst_ni;
  assign a_hs      = a_valid_i & a_ready_o;
  assign b_hs      = b_valid_i & b_ready_o;

  // Next write-port contents and grant history from this cycle's handshake.
  always_comb begin
    last_grant_d = last_grant_q;
    rd_en_d      = 1'b0;
    rd_d         = rd_q;
    rd_data_d    = rd_data_q;
    if (a_hs) begin
      last_grant_d = GRANT_A;
      if (a_rd_i != ZERO_RD) begin
        rd_en_d   = 1'b1;
        rd_d      = a_rd_i;
        rd_data_d = a_data_i;
      end else begin
        rd_en_d   = 1'b0;
      end
    end else if (b_hs) begin
      last_grant_d = GRANT_B;
      if (b_rd_i != ZERO_RD) begin
        rd_en_d   = 1'b1;
        rd_d      = b_rd_i;
        rd_data_d = b_data_i;
      end else begin
        rd_en_d   = 1'b0;
      end
    end else begin
      rd_en_d = 1'b0;
    end
  end

  // Write-port and grant-history registers; reset makes A win first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= GRANT_B;
      rd_en_q      <= 1'b0;
      rd_q         <= '0;
      rd_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_en_q      <= rd_en_d;
      rd_q         <= rd_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_o      = rd_q;
  assign rd_data_o = rd_data_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [2**ADDR_SIZE-1:0] busy_q, busy_d;

  // Retire clears first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (b_hs) begin
      busy_d[b_rd_i] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_en_i) begin
      busy_d[issue_rd_i] = 1'b1;
    end else begin
      busy_d[ZERO_REG] = busy_d[ZERO_REG];
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Pending-write flags register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
`else
  logic unused_issue;

  assign unused_issue = ^{issue_en_i, issue_rd_i};
  assign busy_o       = '0;
`endif

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// random traffic, with a reference model feeding a scoreboard queue that an
// independent negedge monitor drains.
module tb_regfile_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        a_valid_i, b_valid_i, issue_en_i;
  logic [4:0]  a_rd_i, b_rd_i, issue_rd_i, rd_o;
  logic [31:0] a_data_i, b_data_i, rd_data_o, busy_o;
  logic        a_ready_o, b_ready_o, rd_en_o;

  regfile_wb_arbiter dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .a_valid_i  (a_valid_i),
    .a_rd_i     (a_rd_i),
    .a_data_i   (a_data_i),
    .a_ready_o  (a_ready_o),
    .b_valid_i  (b_valid_i),
    .b_rd_i     (b_rd_i),
    .b_data_i   (b_data_i),
    .b_ready_o  (b_ready_o),
    .rd_en_o    (rd_en_o),
    .rd_o       (rd_o),
    .rd_data_o  (rd_data_o),
    .issue_en_i (issue_en_i),
    .issue_rd_i (issue_rd_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  // Reference model state: which requester won last (1 = B), pending flags.
  bit          last_was_b = 1'b1;
  bit          nxt_last_was_b = 1'b1;
  logic [31:0] exp_busy = 32'd0;
  logic [31:0] nxt_busy = 32'd0;
  logic        exp_a_ready = 1'b0;
  logic        exp_b_ready = 1'b0;
  logic [4:0]  hold_rd = 5'd0;
  logic [31:0] hold_data = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the model predicts readies and future writes.
  task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit bv, input logic [4:0] brd, input logic [31:0] bd,
                      input bit ie, input logic [4:0] ird);
    bit ga, gb;
    wr_t e;
    @(posedge clk_i);
    #1;
    cyc++;
    exp_busy   = nxt_busy;
    last_was_b = nxt_last_was_b;
    rst_ni     = r;
    a_valid_i  = av; a_rd_i = ard; a_data_i = ad;
    b_valid_i  = bv; b_rd_i = brd; b_data_i = bd;
    issue_en_i = ie; issue_rd_i = ird;
    if (!r) begin
      exp_q.delete();
      exp_busy       = 32'd0;
      nxt_busy       = 32'd0;
      last_was_b     = 1'b1;
      nxt_last_was_b = 1'b1;
      exp_a_ready    = 1'b0;
      exp_b_ready    = 1'b0;
    end else begin
      ga = av && (!bv || last_was_b);
      gb = bv && !ga;
      exp_a_ready = ga;
      exp_b_ready = gb;
      nxt_last_was_b = ga ? 1'b0 : (gb ? 1'b1 : last_was_b);
      nxt_busy = exp_busy;
`ifdef REGFILE_WB_SCOREBOARD_EN
      if (gb) nxt_busy[brd] = 1'b0;
      if (ie) nxt_busy[ird] = 1'b1;
      nxt_busy[0] = 1'b0;
`endif
      if (ga && ard != 5'd0) begin
        e.cyc = cyc + 1; e.rd = ard; e.data = ad; exp_q.push_back(e);
      end
      if (gb && brd != 5'd0) begin
        e.cyc = cyc + 1; e.rd = brd; e.data = bd; exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // Monitor: compare DUT outputs against the model away from the active edge.
  always @(negedge clk_i) begin
    wr_t e;
    chk("a_ready", {31'd0, a_ready_o}, {31'd0, exp_a_ready});
    chk("b_ready", {31'd0, b_ready_o}, {31'd0, exp_b_ready});
    chk("busy", busy_o, exp_busy);
    if (!rst_ni) begin
      hold_rd   = 5'd0;
      hold_data = 32'd0;
      chk("rst_rd_en", {31'd0, rd_en_o}, 32'd0);
      chk("rst_rd", {27'd0, rd_o}, 32'd0);
      chk("rst_rd_data", rd_data_o, 32'd0);
    end else if (rd_en_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {31'd0, rd_en_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_cycle", cyc, e.cyc);
        chk("write_rd", {27'd0, rd_o}, {27'd0, e.rd});
        chk("write_data", rd_data_o, e.data);
        hold_rd   = e.rd;
        hold_data = e.data;
      end
    end else begin
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_write", {31'd0, rd_en_o}, 32'd1);
      end
      chk("hold_rd", {27'd0, rd_o}, {27'd0, hold_rd});
      chk("hold_data", rd_data_o, hold_data);
    end
  end

  initial begin
    rst_ni = 1'b0;
    a_valid_i = 1'b0; a_rd_i = 5'd0; a_data_i = 32'd0;
    b_valid_i = 1'b0; b_rd_i = 5'd0; b_data_i = 32'd0;
    issue_en_i = 1'b0; issue_rd_i = 5'd0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    // Contention from reset: expect A, B, A, B.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 5'(i + 1), 32'hA000 + 32'(i), 1'b1, 5'(i + 11), 32'hB000 + 32'(i), 1'b0, 5'd0);
    idle(1);
    // Lone A request.
    step(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle(1);
    // B write to the zero register is accepted but not written.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
    idle(1);
    // Scoreboard: issue r7, retire three cycles later; issue and retire r9 together.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    idle(2);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0);
    idle(1);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999, 1'b1, 5'd9);
    idle(1);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    idle(1);
    // Reset dropped mid-contention with r3 pending; A must win afterwards.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    step(1'b1, 1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
    step(1'b0, 1'b1, 5'd2, 32'h23, 1'b1, 5'd6, 32'h67, 1'b0, 5'd0);
    step(1'b0, 1'b1, 5'd2, 32'h24, 1'b1, 5'd6, 32'h68, 1'b0, 5'd0);
    step(1'b1, 1'b1, 5'd2, 32'h25, 1'b1, 5'd6, 32'h69, 1'b0, 5'd0);
    step(1'b1, 1'b1, 5'd2, 32'h26, 1'b1, 5'd6, 32'h6A, 1'b0, 5'd0);
    idle(1);
    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) != 0,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
    idle(3);
    @(negedge clk_i);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
